// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_pkg
//  Purpose  : Shared definitions for the I2C byte engine: quarter-phase state
//             encodings, the default divisor width, read/write encodings and
//             the helper that decides whether the master pulls SDA low for
//             the bit currently on the bus.
//  Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  // Default width of the clock divisor and the quarter counter.
  localparam int k_div_width_default = 16;

  // Quarter-phase FSM encodings (explicit 4-bit width).
  typedef logic [3:0] quarter_state_t;
  localparam quarter_state_t k_idle = 4'd0;
  localparam quarter_state_t k_q0   = 4'd1;
  localparam quarter_state_t k_q1   = 4'd2;
  localparam quarter_state_t k_q2   = 4'd3;
  localparam quarter_state_t k_q3   = 4'd4;

  // Transfer direction encodings.
  localparam logic k_write = 1'b0;
  localparam logic k_read  = 1'b1;

  // Returns 1 when the master must pull SDA low for the current bit.
  // Data bits are driven only when writing; the ACK bit only when reading.
  function automatic logic sda_drive(input logic rw, input logic data_bit,
                                     input logic is_ack, input logic ack_val);
    logic pull;
    if (is_ack) begin
      pull = (rw == k_read) ? ~ack_val : 1'b0;
    end else begin
      pull = (rw == k_write) ? ~data_bit : 1'b0;
    end
    return pull;
  endfunction

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_quarter_timer.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_quarter_timer
//  Purpose  : Quarter-phase timer. Counts CLK cycles up to the (latched)
//             divisor and emits a one-cycle terminal-count pulse, after which
//             the count restarts from zero. Supports clear and hold.
//  Ports    : CLK, RESET_N  - clock, asynchronous active-low reset
//             clear         - force the count to zero, suppress tc
//             hold          - freeze the count, suppress tc (clock stretch)
//             divisor       - terminal value (quarter length minus one)
//             tc            - terminal-count pulse
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_quarter_timer
  import i2c_pkg::*;
#(
  parameter int DIV_WIDTH = k_div_width_default
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 clear,
  input  logic                 hold,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 tc
);

  logic [DIV_WIDTH-1:0] ctr;

  // Full-width equality so that an all-ones divisor is a legal terminal value.
  assign tc = ~clear & ~hold & (ctr == divisor);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ctr <= '0;
    end else if (clear || tc) begin
      ctr <= '0;
    end else if (!hold) begin
      ctr <= ctr + DIV_WIDTH'(1);
    end
  end

endmodule : i2c_quarter_timer
`default_nettype wire

// File: rtl/i2c_byte_engine.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_byte_engine
//  Purpose  : I2C master data-phase engine. Shifts DATA_BITS data bits plus
//             the ACK bit on/off the bus, each bit split into four quarters
//             (Q0..Q3) timed by a programmable divisor, with SCL stretching,
//             abort and a start/done handshake.
//  Ports    : CLK, RESET_N        - clock, asynchronous active-low reset
//             clock_divisor       - quarter length minus one (latched on start)
//             start               - begin a byte when idle
//             rw                  - 1 = read, 0 = write (latched on start)
//             tx_data             - byte to send MSB-first (latched on start)
//             ack_out             - ACK driven in read mode (latched on start)
//             abort               - drop the current byte
//             SDA_in, SCL_in      - sampled bus lines
//             SDA_oe, SCL_oe      - 1 = pull the line low
//             busy, done          - in progress / one-cycle completion pulse
//             rx_data, ack_in     - received bits and sampled ACK
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_byte_engine
  import i2c_pkg::*;
#(
  parameter int DIV_WIDTH = k_div_width_default,
  parameter int DATA_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [DIV_WIDTH-1:0] clock_divisor,
  input  logic                 start,
  input  logic                 rw,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 ack_out,
  input  logic                 abort,
  input  logic                 SDA_in,
  input  logic                 SCL_in,
  output logic                 SDA_oe,
  output logic                 SCL_oe,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 ack_in
);

  localparam int             IDX_W    = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS);

  quarter_state_t       state;
  quarter_state_t       state_nxt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS:0]   shift;
  logic [DATA_BITS-1:0] tx_shift;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 rw_q;
  logic                 ack_out_q;
  logic                 done_q;

  logic                 tc;
  logic                 timer_clear;
  logic                 timer_hold;
  logic                 last_bit;
  logic                 start_take;
  logic                 bit_drive;

  assign last_bit    = (bit_idx == LAST_IDX);
  // abort beats start when both arrive in IDLE.
  assign start_take  = (state == k_idle) && start && !abort;
  // Clearing on abort also masks tc, giving abort priority over a terminal
  // count in the same cycle.
  assign timer_clear = (state == k_idle) || abort;
  assign timer_hold  = (state == k_q1) && !SCL_in;
  // tx_shift presents the current data bit at its MSB; it only moves at the
  // end of Q3, so the SDA decision is stable across all four quarters.
  assign bit_drive   = sda_drive(rw_q, tx_shift[DATA_BITS-1], last_bit, ack_out_q);

  i2c_quarter_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_timer (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clear   (timer_clear),
    .hold    (timer_hold),
    .divisor (div_q),
    .tc      (tc)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= k_idle;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      k_idle:  if (start_take) state_nxt = k_q0;
      k_q0:    if (tc) state_nxt = k_q1;
      k_q1:    if (tc) state_nxt = k_q2;
      k_q2:    if (tc) state_nxt = k_q3;
      k_q3:    if (tc) state_nxt = last_bit ? k_idle : k_q0;
      default: state_nxt = k_idle;
    endcase
    if (abort && (state != k_idle)) begin
      state_nxt = k_idle;
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    SCL_oe = 1'b0;
    SDA_oe = 1'b0;
    busy   = 1'b0;
    case (state)
      k_q0, k_q3: begin
        SCL_oe = 1'b1;
        SDA_oe = bit_drive;
        busy   = 1'b1;
      end
      k_q1, k_q2: begin
        SDA_oe = bit_drive;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_idx   <= '0;
      shift     <= '1;
      tx_shift  <= '0;
      div_q     <= '0;
      rw_q      <= k_write;
      ack_out_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_take) begin
        div_q     <= clock_divisor;
        rw_q      <= rw;
        tx_shift  <= tx_data;
        ack_out_q <= ack_out;
        shift     <= '1;
        bit_idx   <= '0;
      end
      // Single sample point per bit, taken even in write mode so rx_data
      // echoes the bus for arbitration readback.
      if ((state == k_q2) && tc) begin
        shift <= {shift[DATA_BITS-1:0], SDA_in};
      end
      if ((state == k_q3) && tc) begin
        if (last_bit) begin
          done_q <= 1'b1;
        end else begin
          bit_idx  <= bit_idx + IDX_W'(1);
          tx_shift <= tx_shift << 1;
        end
      end
    end
  end

  assign done    = done_q;
  assign rx_data = shift[DATA_BITS:1];
  assign ack_in  = shift[0];

endmodule : i2c_byte_engine
`default_nettype wire

// File: tb/tb_i2c_byte_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_byte_engine
//  Purpose  : Self-checking bench for i2c_byte_engine. A bus model wires SDA
//             as open drain (master pull-down AND slave bit); expected
//             results come from constant vectors and a bit-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_byte_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] div;
  logic        start, rw, ack_out, abort, sda_in, scl_in;
  logic [7:0]  tx_data;
  logic        sda_oe, scl_oe, busy, done, ack_in;
  logic [7:0]  rx_data;

  i2c_byte_engine #(.DIV_WIDTH(16), .DATA_BITS(8)) u_dut (
    .CLK(clk), .RESET_N(rst_n), .clock_divisor(div), .start(start), .rw(rw),
    .tx_data(tx_data), .ack_out(ack_out), .abort(abort), .SDA_in(sda_in),
    .SCL_in(scl_in), .SDA_oe(sda_oe), .SCL_oe(scl_oe), .busy(busy),
    .done(done), .rx_data(rx_data), .ack_in(ack_in)
  );

  // Narrow-divisor instance so an all-ones divisor fits in the run time.
  logic       start4;
  logic       sda_oe4, scl_oe4, busy4, done4, ack_in4;
  logic [7:0] rx_data4;
  logic [3:0] div4;
  logic [7:0] tx4;
  logic       sda_in4;

  i2c_byte_engine #(.DIV_WIDTH(4), .DATA_BITS(8)) u_dut4 (
    .CLK(clk), .RESET_N(rst_n), .clock_divisor(div4), .start(start4), .rw(1'b0),
    .tx_data(tx4), .ack_out(1'b0), .abort(1'b0), .SDA_in(sda_in4),
    .SCL_in(1'b1), .SDA_oe(sda_oe4), .SCL_oe(scl_oe4), .busy(busy4),
    .done(done4), .rx_data(rx_data4), .ack_in(ack_in4)
  );

  // ---------------------------------------------------------------- bus model
  // slave[8] is the first bit on the bus, slave[0] the ACK slot.
  logic [8:0] slave = 9'h1FF;
  logic [8:0] oe_log = 9'h000;
  int         fall_cnt = 0;
  logic       scl_d = 1'b0;
  logic       clr_cnt = 1'b0;

  always @(posedge clk) begin
    scl_d <= scl_oe;
    if (clr_cnt) begin
      fall_cnt <= 0;
    end else if (scl_d && !scl_oe) begin
      if (fall_cnt < 9) oe_log[8-fall_cnt] <= sda_oe;
      fall_cnt <= fall_cnt + 1;
    end
  end

  always_comb begin
    sda_in = 1'b1;
    if (fall_cnt >= 1 && fall_cnt <= 9) sda_in = ~sda_oe & slave[9-fall_cnt];
  end

  // ---------------------------------------------------------------- checking
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] div;
    logic        rw;
    logic [7:0]  tx;
    logic        ao;
    logic [8:0]  slave;
    logic [8:0]  exp_oe;
    logic [7:0]  exp_rx;
    logic        exp_ack;
    int          exp_lat;
  } vec_t;

  // Bit-level model: which bits the master pulls low, then the wired-AND bus.
  function automatic vec_t model(input logic [15:0] d, input logic r,
                                 input logic [7:0] tx, input logic ao,
                                 input logic [8:0] sl);
    vec_t v;
    logic [8:0] bus;
    v.div = d; v.rw = r; v.tx = tx; v.ao = ao; v.slave = sl;
    for (int k = 0; k < 8; k++) v.exp_oe[8-k] = r ? 1'b0 : ~tx[7-k];
    v.exp_oe[0] = r ? ~ao : 1'b0;
    bus = ~v.exp_oe & sl;
    v.exp_rx  = bus[8:1];
    v.exp_ack = bus[0];
    v.exp_lat = 9 * 4 * (int'(d) + 1);
    return v;
  endfunction

  // Called #1 after the edge that accepted start.
  task automatic wait_byte(input vec_t v, input string tag,
                           input int sbit, input int slen);
    int cyc = 0;
    bit stretched = 0;
    start = 1'b0;
    clr_cnt = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    while (!done && cyc < 20000) begin
      if (!stretched && slen > 0 && fall_cnt == sbit && !scl_oe) begin
        scl_in = 1'b0;
        repeat (slen) begin @(posedge clk); #1; cyc++; end
        scl_in = 1'b1;
        stretched = 1;
      end else begin
        @(posedge clk); #1; cyc++;
      end
    end
    chk({tag, ".latency"}, cyc, v.exp_lat);
    chk({tag, ".rx_data"}, rx_data, v.exp_rx);
    chk({tag, ".ack_in"}, ack_in, v.exp_ack);
    chk({tag, ".sda_oe_bits"}, oe_log, v.exp_oe);
    chk({tag, ".busy_at_done"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, done, 0);
  endtask

  task automatic run_byte(input vec_t v, input string tag, input int sbit, input int slen);
    div = v.div; rw = v.rw; tx_data = v.tx; ack_out = v.ao; slave = v.slave;
    start = 1'b1; clr_cnt = 1'b1;
    @(posedge clk); #1;
    wait_byte(v, tag, sbit, slen);
  endtask

  vec_t tbl [5];
  vec_t rv;
  bit   saw_done;

  initial begin
    //            div    rw  tx     ao  slave    exp_oe   rx     ack lat
    tbl[0] = '{16'd3, 0, 8'hA5, 0, 9'h1FE, 9'h0B4, 8'hA5, 0, 144};
    tbl[1] = '{16'd0, 1, 8'h00, 1, 9'h079, 9'h000, 8'h3C, 1, 36};
    tbl[2] = '{16'd2, 1, 8'h55, 0, 9'h1E1, 9'h001, 8'hF0, 0, 108};
    tbl[3] = '{16'd1, 0, 8'h00, 0, 9'h1FF, 9'h1FE, 8'h00, 1, 72};
    tbl[4] = '{16'd1, 0, 8'hFF, 1, 9'h01F, 9'h000, 8'h0F, 1, 72};

    rst_n = 1'b0; div = '0; start = 0; rw = 0; ack_out = 0; abort = 0;
    scl_in = 1'b1; tx_data = '0;
    start4 = 0; div4 = 4'hF; tx4 = 8'h00; sda_in4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.sda_oe", sda_oe, 0);
    chk("reset.scl_oe", scl_oe, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.rx_data", rx_data, 8'hFF);
    chk("reset.ack_in", ack_in, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Constant vectors from the test plan.
    foreach (tbl[i]) run_byte(tbl[i], $sformatf("vec%0d", i), 0, 0);

    // Clock stretch: 10 held cycles in Q1 of bit 2 delay done by exactly 10.
    rv = tbl[0]; rv.div = 16'd1; rv.exp_lat = 72 + 10;
    run_byte(rv, "stretch", 2, 10);

    // abort together with start in IDLE: start ignored.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_start.busy", busy, 0);

    // Abort in Q2 of bit 5 (divisor 1: bit k Q2 entered 8k+4 edges after start).
    div = 16'd1; rw = 0; tx_data = 8'h96; ack_out = 0; slave = 9'h1FF;
    start = 1'b1; clr_cnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clr_cnt = 1'b0;
    repeat (44) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.sda_oe", sda_oe, 0);
    chk("abort.scl_oe", scl_oe, 0);
    chk("abort.rx_partial", rx_data, 8'hF9);
    chk("abort.ack_partial", ack_in, 0);
    saw_done = done;
    repeat (20) begin @(posedge clk); #1; saw_done |= done; end
    chk("abort.no_done", saw_done, 0);
    run_byte(tbl[0], "after_abort", 0, 0);

    // Reset mid-byte with start held high; a clean byte follows release.
    rv = tbl[0]; rv.div = 16'd1; rv.exp_lat = 72;
    div = rv.div; rw = rv.rw; tx_data = rv.tx; ack_out = rv.ao; slave = rv.slave;
    start = 1'b1; clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("pre_reset.scl_oe", scl_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset.scl_oe", scl_oe, 0);
    chk("mid_reset.sda_oe", sda_oe, 0);
    chk("mid_reset.busy", busy, 0);
    chk("mid_reset.rx_data", rx_data, 8'hFF);
    chk("mid_reset.ack_in", ack_in, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; clr_cnt = 1'b1;
    @(posedge clk); #1;
    wait_byte(rv, "post_reset", 0, 0);

    // Randomised bytes against the model.
    for (int n = 0; n < 12; n++) begin
      rv = model(16'($urandom_range(0, 3)), 1'($urandom), 8'($urandom),
                 1'($urandom), 9'($urandom));
      run_byte(rv, $sformatf("rand%0d", n), 0, 0);
    end

    // All-ones divisor on a 4-bit counter: 16-cycle quarters, SDA_in=0.
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("div_ones.q0_held", scl_oe4, 1);
    @(posedge clk); #1;
    chk("div_ones.q1_entered", scl_oe4, 0);
    repeat (31) @(posedge clk);
    #1;
    chk("div_ones.before_tc_ack", ack_in4, 1);
    chk("div_ones.before_tc_scl", scl_oe4, 0);
    @(posedge clk); #1;
    chk("div_ones.at_tc_shift", {rx_data4, ack_in4}, 9'h1FE);
    chk("div_ones.q3_entered", scl_oe4, 1);
    begin
      int cyc = 48;
      while (!done4 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
      chk("div_ones.latency", cyc, 9 * 4 * 16);
    end
    chk("div_ones.rx_data", rx_data4, 8'h00);
    chk("div_ones.ack_in", ack_in4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_i2c_byte_engine
`default_nettype wire
